// File: rtl/lane_sprite_mover_if.sv
// Pixel stream from the sprite mover to the shared VGA write arbiter.
// Latency: none, pure wiring bundle.
// Backpressure: a pixel transfers when vga_write && vga_ready; master holds while not ready.
interface lane_sprite_mover_if #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9
);
    logic [nX-1:0]          vga_x;
    logic [nY-1:0]          vga_y;
    logic [COLOR_DEPTH-1:0] vga_color;
    logic                   vga_write;
    logic                   vga_ready;

    modport master (output vga_x, vga_y, vga_color, vga_write, input vga_ready);
    modport slave  (input vga_x, vga_y, vga_color, vga_write, output vga_ready);
endinterface

// File: rtl/lane_sprite_mover.sv
// Moves a sprite between lanes: erases with background, redraws skipping transparent pixels.
// Latency: request edge E0 -> first pixel valid after E2; one pixel slot per unstalled cycle.
// Backpressure: whole counter/tag/output pipeline and both memories freeze while write && !ready.
module lane_sprite_mover #(
    parameter int nX                = 10,
    parameter int nY                = 9,
    parameter int COLOR_DEPTH       = 9,
    parameter int NUM_LANES         = 5,
    parameter int LANE_BITS         = 3,
    parameter int LANE_WIDTH        = 80,
    parameter int LANE_START_X      = 120,
    parameter int SPRITE_W          = 60,
    parameter int SPRITE_H          = 60,
    parameter int SPRITE_Y          = 360,
    parameter int START_LANE        = 2,
    parameter int SPR_ADDR_W        = 12,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = 9'b111_000_111
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_move_left,
    input  logic                   i_move_right,
    input  logic                   i_redraw,
    output logic [LANE_BITS-1:0]   o_player_lane,
    output logic                   o_busy,
    output logic                   o_mem_en,
    output logic [SPR_ADDR_W-1:0]  o_spr_addr,
    input  logic [COLOR_DEPTH-1:0] i_spr_data,
    output logic [nX-1:0]          o_bg_x,
    output logic [nY-1:0]          o_bg_y,
    input  logic [COLOR_DEPTH-1:0] i_bg_data,
    lane_sprite_mover_if.master    vga
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    typedef enum logic [2:0] {ST_RST, ST_INIT, ST_DRAW, ST_ERASE, ST_IDLE} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LEFT, REQ_RIGHT, REQ_REDRAW} req_t;

    function automatic logic [nX-1:0] f_lane_x(input logic [LANE_BITS-1:0] lane);
        return nX'(LANE_START_X + int'(lane) * LANE_WIDTH + (LANE_WIDTH - SPRITE_W) / 2);
    endfunction

    state_t                 r_state;
    logic [LANE_BITS-1:0]   r_lane;
    logic [nX-1:0]          r_old_x;
    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic                   r_cnt_act;
    req_t                   r_pend;
    logic                   r_prev_l, r_prev_r, r_prev_d;

    // tag stage: slot whose memory read is in flight
    logic                   r_t_vld, r_t_erase, r_t_last;
    logic [nX-1:0]          r_t_x;
    logic [nY-1:0]          r_t_y;

    // output register: r_o_slot marks an occupied slot even when transparent
    logic                   r_o_vld, r_o_slot, r_o_last;
    logic [nX-1:0]          r_o_x;
    logic [nY-1:0]          r_o_y;
    logic [COLOR_DEPTH-1:0] r_o_color;

    logic                   w_adv, w_req_l, w_req_r, w_req_d, w_scan_end, w_last, w_done;
    req_t                   w_new_req, w_cmd;
    logic [nX-1:0]          w_base_x, w_pix_x;
    logic [nY-1:0]          w_pix_y;

    assign w_adv      = ~(r_o_vld & ~vga.vga_ready);
    assign w_req_l    = i_move_left  & ~r_prev_l;
    assign w_req_r    = i_move_right & ~r_prev_r;
    assign w_req_d    = i_redraw     & ~r_prev_d;
    assign w_base_x   = (r_state == ST_ERASE) ? r_old_x : f_lane_x(r_lane);
    assign w_pix_x    = w_base_x + nX'(r_col);
    assign w_pix_y    = nY'(SPRITE_Y) + nY'(r_row);
    assign w_scan_end = (r_col == CW'(SPRITE_W - 1)) && (r_row == RW'(SPRITE_H - 1));
    assign w_last     = w_scan_end && (r_state == ST_DRAW);
    assign w_done     = r_o_slot && r_o_last && w_adv;
    assign w_cmd      = (w_new_req != REQ_NONE) ? w_new_req : r_pend;

    // Decode this cycle's request; simultaneous left+right cancel, a move beats redraw
    always_comb begin
        w_new_req = REQ_NONE;
        if (w_req_l && !w_req_r)      w_new_req = REQ_LEFT;
        else if (w_req_r && !w_req_l) w_new_req = REQ_RIGHT;
        else if (w_req_d)             w_new_req = REQ_REDRAW;
    end

    // Previous input levels for rising-edge detection
    always_ff @(posedge clk) begin
        r_prev_l <= i_move_left;
        r_prev_r <= i_move_right;
        r_prev_d <= i_redraw;
    end

    // Control FSM, lane state, pending slot and raster counter
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= ST_RST;
            r_lane    <= LANE_BITS'(START_LANE);
            r_old_x   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_cnt_act <= 1'b0;
            r_pend    <= REQ_NONE;
        end else begin
            if (r_state != ST_IDLE && w_new_req != REQ_NONE)
                r_pend <= w_new_req;
            if (r_cnt_act && w_adv) begin
                if (r_col == CW'(SPRITE_W - 1)) begin
                    r_col <= '0;
                    if (r_row == RW'(SPRITE_H - 1)) begin
                        r_row <= '0;
                        // ERASE rolls straight into DRAW with the counter still running
                        if (r_state != ST_ERASE) r_cnt_act <= 1'b0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            case (r_state)
                ST_RST:   r_state <= ST_INIT;
                ST_INIT: begin
                    r_state   <= ST_DRAW;
                    r_cnt_act <= 1'b1;
                end
                ST_ERASE: if (w_scan_end && w_adv) r_state <= ST_DRAW;
                ST_DRAW:  if (w_done) r_state <= ST_IDLE;
                ST_IDLE: begin
                    r_pend <= REQ_NONE;
                    case (w_cmd)
                        REQ_LEFT: if (r_lane != '0) begin
                            r_old_x   <= f_lane_x(r_lane);
                            r_lane    <= r_lane - LANE_BITS'(1);
                            r_state   <= ST_ERASE;
                            r_cnt_act <= 1'b1;
                        end
                        REQ_RIGHT: if (r_lane != LANE_BITS'(NUM_LANES - 1)) begin
                            r_old_x   <= f_lane_x(r_lane);
                            r_lane    <= r_lane + LANE_BITS'(1);
                            r_state   <= ST_ERASE;
                            r_cnt_act <= 1'b1;
                        end
                        REQ_REDRAW: begin
                            r_state   <= ST_DRAW;
                            r_cnt_act <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    // Tag and output stages; both freeze together with the memories on a stall
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_t_vld   <= 1'b0;
            r_t_erase <= 1'b0;
            r_t_last  <= 1'b0;
            r_t_x     <= '0;
            r_t_y     <= '0;
            r_o_vld   <= 1'b0;
            r_o_slot  <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_x     <= '0;
            r_o_y     <= '0;
            r_o_color <= '0;
        end else if (w_adv) begin
            r_t_vld   <= r_cnt_act;
            r_t_erase <= (r_state == ST_ERASE);
            r_t_last  <= w_last;
            r_t_x     <= w_pix_x;
            r_t_y     <= w_pix_y;
            r_o_slot  <= r_t_vld;
            r_o_last  <= r_t_last;
            r_o_vld   <= r_t_vld && (r_t_erase || i_spr_data != TRANSPARENT_COLOR);
            r_o_x     <= r_t_x;
            r_o_y     <= r_t_y;
            r_o_color <= r_t_erase ? i_bg_data : i_spr_data;
        end
    end

    assign o_player_lane = r_lane;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_mem_en      = w_adv;
    assign o_spr_addr    = SPR_ADDR_W'(int'(r_row) * SPRITE_W + int'(r_col));
    assign o_bg_x        = w_pix_x;
    assign o_bg_y        = w_pix_y;
    assign vga.vga_x     = r_o_x;
    assign vga.vga_y     = r_o_y;
    assign vga.vga_color = r_o_color;
    assign vga.vga_write = r_o_vld;
endmodule

// File: tb/tb_lane_sprite_mover.sv
// Scoreboard bench for lane_sprite_mover with sprite/background memory models.
// Latency: memory models return q one cycle after an enabled read.
// Backpressure: ready is driven high or randomly low about 30% of cycles.
module tb_lane_sprite_mover;
    logic       clk = 1'b0;
    logic       rst;
    logic       move_left, move_right, redraw;
    logic [2:0] lane;
    logic       busy, mem_en;
    logic [11:0] spr_addr;
    logic [8:0] spr_q, bg_q;
    logic [9:0] bg_x;
    logic [8:0] bg_y;
    logic       stall_en;

    typedef struct {
        int         x;
        int         y;
        logic [8:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pop_cnt = 0;
    int   lane_x_tab[5] = '{130, 210, 290, 370, 450};

    lane_sprite_mover_if #(.nX(10), .nY(9), .COLOR_DEPTH(9)) vif ();

    lane_sprite_mover dut (
        .clk          (clk),
        .i_reset      (rst),
        .i_move_left  (move_left),
        .i_move_right (move_right),
        .i_redraw     (redraw),
        .o_player_lane(lane),
        .o_busy       (busy),
        .o_mem_en     (mem_en),
        .o_spr_addr   (spr_addr),
        .i_spr_data   (spr_q),
        .o_bg_x       (bg_x),
        .o_bg_y       (bg_y),
        .i_bg_data    (bg_q),
        .vga          (vif)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] spr_f(input int a);
        if (a % 7 == 3) return 9'h1C7;
        return 9'(a * 5 + 1);
    endfunction

    function automatic logic [8:0] bg_f(input int x, input int y);
        return 9'(x * 3 + y * 7);
    endfunction

    // Memory models: one-cycle read latency, q held while enable is low
    always @(posedge clk) begin
        if (mem_en) begin
            spr_q <= spr_f(int'(spr_addr));
            bg_q  <= bg_f(int'(bg_x), int'(bg_y));
        end
    end

    // Arbiter ready, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        vif.vga_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_scan(input int ln, input bit erase);
        for (int r = 0; r < 60; r++) begin
            for (int c = 0; c < 60; c++) begin
                pix_t p;
                p.x = lane_x_tab[ln] + c;
                p.y = 360 + r;
                if (erase) begin
                    p.c = bg_f(p.x, p.y);
                    exp_q.push_back(p);
                end else begin
                    p.c = spr_f(r * 60 + c);
                    if (p.c != 9'h1C7) exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic pulse(input logic l, input logic r, input logic d);
        @(negedge clk);
        move_left = l; move_right = r; redraw = d;
        @(posedge clk);
        #1;
        move_left = 1'b0; move_right = 1'b0; redraw = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input int exp_lane, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy || lane != 3'(exp_lane)) && n < budget);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_lane"}, int'(lane), exp_lane);
        chk({name, "_left_in_queue"}, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: pops on every handshake, checks hold during stalls
    logic       held = 1'b0;
    int         hx, hy;
    logic [8:0] hc;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_cmp++;
                if (int'(vif.vga_x) != hx || int'(vif.vga_y) != hy || vif.vga_color != hc) begin
                    n_bad++;
                    $display("FAIL stall_hold: got (%0d,%0d,%h) held was (%0d,%0d,%h)",
                             vif.vga_x, vif.vga_y, vif.vga_color, hx, hy, hc);
                end
                held = 1'b0;
            end
            if (vif.vga_write && vif.vga_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d,%h) expected none",
                             vif.vga_x, vif.vga_y, vif.vga_color);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (int'(vif.vga_x) != e.x || int'(vif.vga_y) != e.y || vif.vga_color != e.c) begin
                        n_bad++;
                        $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                                 vif.vga_x, vif.vga_y, vif.vga_color, e.x, e.y, e.c);
                    end
                end
                pop_cnt++;
            end else if (vif.vga_write) begin
                held = 1'b1;
                hx = int'(vif.vga_x);
                hy = int'(vif.vga_y);
                hc = vif.vga_color;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; move_left = 1'b0; move_right = 1'b0; redraw = 1'b0;
        stall_en = 1'b0; vif.vga_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", int'(vif.vga_write), 0);
        chk("rst_x", int'(vif.vga_x), 0);
        chk("rst_y", int'(vif.vga_y), 0);
        chk("rst_color", int'(vif.vga_color), 0);
        chk("rst_lane", int'(lane), 2);
        chk("rst_busy", int'(busy), 1);
        chk("rst_mem_en", int'(mem_en), 1);
        chk("rst_spr_addr", int'(spr_addr), 0);

        // Initial draw at lane 2, no erase
        push_scan(2, 1'b0);
        @(negedge clk) rst = 1'b0;
        wait_idle(5000, 2, "init_draw");

        // Move left 2->1: acceptance-edge lane, 2-cycle latency, 7202-cycle total
        push_scan(2, 1'b1);
        push_scan(1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("ml_lane_at_accept", int'(lane), 1);
        chk("ml_busy_at_accept", int'(busy), 1);
        @(negedge clk);
        chk("ml_write_after_e0", int'(vif.vga_write), 0);
        @(negedge clk);
        chk("ml_write_after_e1", int'(vif.vga_write), 0);
        @(negedge clk);
        chk("ml_write_after_e2", int'(vif.vga_write), 1);
        n = 2;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 8000);
        chk("ml_cycles_to_idle", n, 7202);
        chk("ml_left_in_queue", exp_q.size(), 0);

        // Move left 1->0 under random backpressure
        stall_en = 1'b1;
        push_scan(1, 1'b1);
        push_scan(0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle(20000, 0, "stall_move");
        stall_en = 1'b0;

        // Out-of-bounds left at lane 0, and left+right together, both ignored
        pulse(1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("lane0_left_busy", int'(busy), 0);
        chk("lane0_left_lane", int'(lane), 0);
        pulse(1'b1, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("both_busy", int'(busy), 0);
        chk("both_lane", int'(lane), 0);

        // Reset around pixel 1000 of an erase
        push_scan(0, 1'b1);
        push_scan(1, 1'b0);
        pop_cnt = 0;
        pulse(1'b0, 1'b1, 1'b0);
        n = 0;
        while (pop_cnt < 1000 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("erase_progress", int'(pop_cnt >= 1000), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_write", int'(vif.vga_write), 0);
        chk("midrst_lane", int'(lane), 2);
        chk("midrst_busy", int'(busy), 1);
        push_scan(2, 1'b0);
        @(negedge clk) rst = 1'b0;
        wait_idle(5000, 2, "post_rst_draw");

        // Two rights while moving 2->3: one queued, ends at lane 4
        push_scan(2, 1'b1);
        push_scan(3, 1'b0);
        push_scan(3, 1'b1);
        push_scan(4, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("q_lane_first", int'(lane), 3);
        repeat (100) @(posedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (100) @(posedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle(20000, 4, "queued_moves");
        repeat (5) @(posedge clk);
        #1;
        chk("queued_no_third_busy", int'(busy), 0);
        chk("queued_no_third_lane", int'(lane), 4);

        // Right at lane 4 ignored
        pulse(1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("lane4_right_busy", int'(busy), 0);
        chk("lane4_right_lane", int'(lane), 4);

        // Redraw in place at lane 4
        push_scan(4, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("redraw_busy", int'(busy), 1);
        wait_idle(5000, 4, "redraw");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lane_sprite_mover.md
# lane_sprite_mover

Parametrised successor to the single-car player block: moves a sprite between N lanes, restores the real background from a background memory when erasing (no solid-colour erase), skips transparent sprite pixels, and streams pixels to the VGA write arbiter over a valid/ready handshake with full backpressure. Move requests arriving mid-redraw are queued (one deep) instead of dropped. Sits between the keyboard/button edge logic and the shared VGA pixel-write arbiter; sprite and background memories sit outside the block.

## Interface
- nX, 10, VGA x width
- nY, 9, VGA y width
- COLOR_DEPTH, 9, pixel colour width
- NUM_LANES, 5, lane count (≥2)
- LANE_BITS, 3, width of lane index
- LANE_WIDTH, 80, lane pitch in pixels
- LANE_START_X, 120, x of lane 0 left edge
- SPRITE_W, 60 / SPRITE_H, 60, sprite size
- SPRITE_Y, 360, sprite top row
- START_LANE, 2, lane after reset
- SPR_ADDR_W, 12, sprite memory address width
- TRANSPARENT_COLOR, 9'b111_000_111, sprite colour never written
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- move_left / move_right  in  1 each  level inputs, rising edge = request
- redraw  in  1  rising edge = redraw sprite at current lane (after screen clear)
- player_lane  out  LANE_BITS  committed lane
- busy  out  1  high whenever not IDLE
- mem_en  out  1  clock enable for both memories (= not stalled)
- spr_addr  out  SPR_ADDR_W  row*SPRITE_W + col
- spr_data  in  COLOR_DEPTH  sprite memory q, 1-cycle latency
- bg_x / bg_y  out  nX / nY  background read coordinates
- bg_data  in  COLOR_DEPTH  background memory q, 1-cycle latency
- VGA_x / VGA_y / VGA_color  out  nX / nY / COLOR_DEPTH  pixel
- VGA_write  out  1  pixel valid
- VGA_ready  in  1  arbiter accepts pixel when VGA_write && VGA_ready

## Operation
- lane_x(l) = LANE_START_X + l*LANE_WIDTH + (LANE_WIDTH−SPRITE_W)/2 (defaults: 130, 210, 290, 370, 450); computed at nX width.
- States: INIT → DRAW → IDLE; IDLE → ERASE → DRAW → IDLE on move; IDLE → DRAW on redraw.
- Edge detect: input registered each cycle; request = input & ~prev. Left and right rising in the same cycle: both ignored.
- Move accepted only if in-bounds (left at lane 0, right at NUM_LANES−1 ignored). On acceptance: old_x ← lane_x(player_lane), player_lane updated same edge, state ERASE.
- ERASE: scan SPRITE_W×SPRITE_H raster-order at old_x, SPRITE_Y; bg_x/bg_y = scan position; emit bg_data, every pixel written.
- DRAW: scan at lane_x(player_lane); spr_addr = row*SPRITE_W+col; pixels equal to TRANSPARENT_COLOR consume a slot but produce VGA_write=0.
- Pipeline: counter → memory/tag stage (x, y, kind) → output register. ERASE→DRAW transitions without draining; IDLE entered once last pixel accepted.
- Pending: requests (move or redraw) while busy latched in one slot, newest overwrites; bounds checked against player_lane when dequeued at IDLE. Move and redraw in same cycle: move wins, redraw discarded.

## Timing
- Reset values: VGA_write 0, VGA_x/y/color 0, player_lane START_LANE, busy 1, mem_en 1, spr_addr 0, pending empty. First edge with Reset low enters INIT; next enters DRAW (no erase).
- Reset mid-scan: pipeline and pending flushed at that edge; VGA_write 0 on the following cycle.
- Request accepted at edge E0 → first VGA_write high after E2. With VGA_ready tied high: 1 pixel/cycle; move = 2·W·H + 2 cycles from E0 to IDLE (7202 at defaults).
- Stall when VGA_write && !VGA_ready: counter, tag stage, output register hold; mem_en=0 same cycle so memory q holds. VGA_x/y/color stable while stalled.
- busy falls the cycle after the last pixel handshake.

## Test plan
- Reset, VGA_ready=1 → 3600 DRAW slots at x 290..349, y 360..419; written pixels exclude all 9'h1C7 sprite entries; player_lane=2; busy low after.
- move_left pulse in IDLE → 3600 bg pixels at x 290..349 with bg_data colours, then draw at x 210; player_lane=1 at acceptance edge; first VGA_write 2 cycles after.
- Lane 0, move_left → no activity, busy stays low; lane 4 move_right likewise; left+right same cycle → ignored.
- VGA_ready random 30% low → every pixel delivered exactly once, in raster order, values unchanged during stalls.
- Two move_right pulses during one move from lane 2 → only latest queued; ends in lane 4 after two full moves (3 then 4).
- Reset asserted at pixel 1000 of ERASE → VGA_write 0 next cycle, then fresh draw at lane 2, no erase.
